dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the 256-byte, big-endian, word-wide data memory. It accepts load/store requests from two requesters over valid/ready handshakes, port 0 being the core load/store stage and port 1 the debug/loader path. It grants one request at a time with round-robin priority and drives the memory's mem_rd/mem_wr strobes so they are never asserted together. It returns read data, or an error flag, on a one-cycle response pulse.

---
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter and access sequencer placed in front of the 256-byte,
// word-wide data memory. Port 0 is the core load/store stage and port 1 is
// the debug/loader path. One request is granted at a time with round-robin
// priority. Each grant runs through a fixed three-cycle sequence:
// grant (IDLE) -> memory strobe (ACCESS) -> response pulse (DONE).
//
// Ports:
//   clk, rst_n        clock (rising edge) and async active-low reset
//   reqN_valid        request present on port N
//   reqN_ready        request accepted on this edge when high with valid
//   reqN_we           1 = store, 0 = load
//   reqN_addr         byte address of the word
//   reqN_wdata        store data
//   rspN_valid        one-cycle response pulse for port N
//   rspN_rdata        load data while rspN_valid, 0 otherwise
//   rspN_err          request rejected (misaligned / out of range)
//   mem_addr          registered memory address, 0 outside ACCESS
//   mem_wr_data       registered memory write data, 0 outside ACCESS
//   mem_wr, mem_rd    registered, mutually exclusive memory strobes
//   mem_rd_data       combinational read data from memory
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,

    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,

    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr,
    output logic        mem_rd,
    input  logic [31:0] mem_rd_data
);

    // Highest byte address at which a full word still fits in the memory.
    localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        last_gnt;
    logic        gnt;
    logic        we_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        grant0;
    logic        grant1;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_err;
    logic [31:0] rsp_data;

    // Round-robin choice between the two ports. A lone valid always wins;
    // on a conflict the port that was not granted last time goes first.
    // These are only candidates: they turn into grants in IDLE.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_gnt);
        grant1 = req1_valid && (!req0_valid || !last_gnt);
    end

    // Steer the winning port's request fields and check the address. An
    // illegal address is still granted so the requester gets an error
    // response rather than stalling forever.
    always_comb begin
        req_we    = grant1 ? req1_we    : req0_we;
        req_addr  = grant1 ? req1_addr  : req0_addr;
        req_wdata = grant1 ? req1_wdata : req0_wdata;
        req_err   = (req_addr[1:0] != 2'b00) || (req_addr > ADDR_MAX);
    end

    // State register. Reset drops straight back to IDLE, abandoning any
    // transaction in flight without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and ready generation. Readies exist only in IDLE and
    // are held low while reset is asserted so nothing looks accepted then.
    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0 && rst_n;
                req1_ready = grant1 && rst_n;
                if (grant0 || grant1) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction registers and memory-side outputs. The memory bus is
    // loaded on the grant edge so address, data and strobe are all stable
    // for the whole ACCESS cycle, and cleared on the edge leaving ACCESS.
    // Because they are reset asynchronously, a reset in ACCESS kills the
    // strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt    <= 1'b1;
            gnt         <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        gnt         <= grant1;
                        last_gnt    <= grant1;
                        we_q        <= req_we;
                        err_q       <= req_err;
                        mem_addr    <= req_addr;
                        mem_wr_data <= req_wdata;
                        mem_wr      <= req_we && !req_err;
                        mem_rd      <= !req_we && !req_err;
                    end
                end
                ACCESS: begin
                    if (mem_rd) begin
                        rdata_q <= mem_rd_data;
                    end
                    mem_addr    <= '0;
                    mem_wr_data <= '0;
                    mem_wr      <= 1'b0;
                    mem_rd      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Response pulse in DONE, routed to the granted port only. Read data is
    // forced to zero for stores and rejected requests, since rdata_q may
    // hold a stale value from an earlier load.
    always_comb begin
        rsp_data   = (!we_q && !err_q) ? rdata_q : '0;
        rsp0_valid = (state == DONE) && !gnt;
        rsp1_valid = (state == DONE) && gnt;
        rsp0_rdata = rsp0_valid ? rsp_data : '0;
        rsp1_rdata = rsp1_valid ? rsp_data : '0;
        rsp0_err   = rsp0_valid && err_q;
        rsp1_err   = rsp1_valid && err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A behavioural memory sits on the
// memory port. A transaction-level reference model tracks grants, expected
// strobes, expected responses and expected memory contents, and compares
// the DUT against it on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req0_valid, req0_ready, req0_we;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        mem_wr, mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .mem_rd_data(mem_rd_data)
    );

    // Behavioural 64-word memory: combinational read, write on rising edge.
    logic [31:0] envMem [64] = '{default: '0};
    assign mem_rd_data = envMem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wr) envMem[mem_addr[7:2]] <= mem_wr_data;
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expErr;
        logic [31:0] expRdata;
    } vec_t;

    typedef struct {
        logic        v;
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } txn_t;

    int          vecCount  = 0;
    int          missCount = 0;
    txn_t        s1, s2;
    logic        lastGnt;
    logic [31:0] refMem [64];
    int          hsCnt [2];
    int          rspCnt [2];

    // Compare a word-sized value against the expectation.
    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Compare a single-bit value against the expectation.
    function automatic void checkFlag(input string name, input logic actual, input logic expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, actual, expected, $time);
        end
    endfunction

    // A word access is legal only if aligned and the whole word is inside memory.
    function automatic logic addrIllegal(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (longint'(a) + 64'd4 > longint'(MEM_BYTES));
    endfunction

    task automatic driveReq(input logic port, input logic valid, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            req1_valid = valid; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = valid; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end
    endtask

    // Reference model, evaluated each falling edge. s1 is the transaction
    // expected to be strobing this cycle, s2 the one expected to respond.
    task automatic monitorLoop();
        logic busy, e0, e1, expWr, expRd, expV0, expV1;
        logic [31:0] expAddr, expWd, expData;
        txn_t nx;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkFlag("rst_req0_ready", req0_ready, 1'b0);
                checkFlag("rst_req1_ready", req1_ready, 1'b0);
                checkFlag("rst_mem_wr", mem_wr, 1'b0);
                checkFlag("rst_mem_rd", mem_rd, 1'b0);
                checkOutput("rst_mem_addr", mem_addr, 32'd0);
                checkOutput("rst_mem_wr_data", mem_wr_data, 32'd0);
                checkFlag("rst_rsp0_valid", rsp0_valid, 1'b0);
                checkFlag("rst_rsp1_valid", rsp1_valid, 1'b0);
                checkOutput("rst_rsp0_rdata", rsp0_rdata, 32'd0);
                checkOutput("rst_rsp1_rdata", rsp1_rdata, 32'd0);
                checkFlag("rst_rsp0_err", rsp0_err, 1'b0);
                checkFlag("rst_rsp1_err", rsp1_err, 1'b0);
                s1.v = 1'b0;
                s2.v = 1'b0;
                lastGnt = 1'b1;
            end else begin
                busy = s1.v || s2.v;
                e0 = !busy && req0_valid && (!req1_valid || lastGnt);
                e1 = !busy && req1_valid && (!req0_valid || !lastGnt);
                checkFlag("mon_req0_ready", req0_ready, e0);
                checkFlag("mon_req1_ready", req1_ready, e1);
                checkFlag("mon_strobe_exclusive", mem_wr & mem_rd, 1'b0);

                expWr   = s1.v && s1.we && !s1.err;
                expRd   = s1.v && !s1.we && !s1.err;
                expAddr = s1.v ? s1.addr : 32'd0;
                expWd   = s1.v ? s1.wdata : 32'd0;
                checkFlag("mon_mem_wr", mem_wr, expWr);
                checkFlag("mon_mem_rd", mem_rd, expRd);
                checkOutput("mon_mem_addr", mem_addr, expAddr);
                checkOutput("mon_mem_wr_data", mem_wr_data, expWd);
                if (expWr) refMem[s1.addr[7:2]] = s1.wdata;
                if (expRd) s1.rdata = refMem[s1.addr[7:2]];

                expV0   = s2.v && !s2.port;
                expV1   = s2.v && s2.port;
                expData = (s2.v && !s2.we && !s2.err) ? s2.rdata : 32'd0;
                checkFlag("mon_rsp0_valid", rsp0_valid, expV0);
                checkFlag("mon_rsp1_valid", rsp1_valid, expV1);
                checkOutput("mon_rsp0_rdata", rsp0_rdata, expV0 ? expData : 32'd0);
                checkOutput("mon_rsp1_rdata", rsp1_rdata, expV1 ? expData : 32'd0);
                if (expV0) checkFlag("mon_rsp0_err", rsp0_err, s2.err);
                if (expV1) checkFlag("mon_rsp1_err", rsp1_err, s2.err);
                if (rsp0_valid) rspCnt[0]++;
                if (rsp1_valid) rspCnt[1]++;

                s2 = s1;
                nx.v     = e0 || e1;
                nx.port  = e1;
                nx.we    = e1 ? req1_we : req0_we;
                nx.addr  = e1 ? req1_addr : req0_addr;
                nx.wdata = e1 ? req1_wdata : req0_wdata;
                nx.err   = addrIllegal(nx.addr);
                nx.rdata = 32'd0;
                if (nx.v) begin
                    lastGnt = e1;
                    hsCnt[e1]++;
                end
                s1 = nx;
            end
        end
    endtask

    // Wait (bounded) for the port's ready; returns at the falling edge
    // before the accepting rising edge.
    task automatic waitReady(input logic port, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) ok = 1'b1;
        end
    endtask

    // Issue one request on one port and observe latency, strobes and response.
    task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic gotErr,
                                 output logic [31:0] gotRdata, output int latency,
                                 output int strobes, output logic timedOut);
        logic ok;
        logic got;
        gotErr = 1'b0; gotRdata = 32'd0; latency = 0; strobes = 0; got = 1'b0;
        @(posedge clk); #1;
        driveReq(port, 1'b1, we, addr, wdata);
        waitReady(port, ok);
        @(posedge clk); #1;
        driveReq(port, 1'b0, we, addr, wdata);
        for (int n = 0; n < 10 && ok && !got; n++) begin
            @(negedge clk);
            latency++;
            if (mem_wr || mem_rd) strobes++;
            if (port ? rsp1_valid : rsp0_valid) begin
                got      = 1'b1;
                gotErr   = port ? rsp1_err : rsp0_err;
                gotRdata = port ? rsp1_rdata : rsp0_rdata;
            end
        end
        timedOut = !got;
    endtask

    task automatic randomReq(input logic port);
        logic        we;
        logic [31:0] addr;
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) addr = 32'($urandom_range(0, 300));
        else addr = 32'($urandom_range(0, 63)) * 32'd4;
        driveReq(port, 1'b1, we, addr, $urandom());
    endtask

    // Safety net in case something blocks outside a bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [12];
        int          g [$];
        logic        gotErr, to, ok, acc0, acc1;
        logic [31:0] gotRdata;
        int          lat, strb, issued, cyc, hs0, hs1, rs0, rs1;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,         1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_00FC, 32'hA5A5_5A5A, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hA5A5_5A5A};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_00F9, 32'h9999_9999, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_00F8, 32'h0,         1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};

        for (int i = 0; i < 64; i++) refMem[i] = 32'd0;
        hsCnt[0] = 0; hsCnt[1] = 0; rspCnt[0] = 0; rspCnt[1] = 0;
        s1.v = 1'b0; s2.v = 1'b0; lastGnt = 1'b1;
        rst_n = 1'b0;
        driveReq(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        driveReq(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        fork
            monitorLoop();
        join_none

        // Conflicting loads held through reset: nothing may be accepted yet.
        driveReq(1'b0, 1'b1, 1'b0, 32'h00, 32'd0);
        driveReq(1'b1, 1'b1, 1'b0, 32'h04, 32'd0);
        repeat (2) @(negedge clk);
        checkFlag("reset_req0_ready", req0_ready, 1'b0);
        checkFlag("reset_req1_ready", req1_ready, 1'b0);
        checkFlag("reset_mem_rd", mem_rd, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] conflict sequence");
        for (int n = 0; n < 40 && g.size() < 4; n++) begin
            @(negedge clk);
            if (req0_ready) g.push_back(0);
            if (req1_ready) g.push_back(1);
        end
        @(posedge clk); #1;
        driveReq(1'b0, 1'b0, 1'b0, 32'h00, 32'd0);
        driveReq(1'b1, 1'b0, 1'b0, 32'h04, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("conflict_grant_count", g.size(), 32'd4);
        for (int i = 0; i < g.size(); i++)
            checkOutput($sformatf("conflict_grant%0d", i), g[i], i % 2);

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          gotErr, gotRdata, lat, strb, to);
            checkFlag($sformatf("vec%0d_timeout", i), to, 1'b0);
            checkFlag($sformatf("vec%0d_err", i), gotErr, vecs[i].expErr);
            checkOutput($sformatf("vec%0d_rdata", i), gotRdata, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d_latency", i), lat, 32'd2);
            checkOutput($sformatf("vec%0d_strobes", i), strb, vecs[i].expErr ? 32'd0 : 32'd1);
        end

        $display("[TB] hold sequence");
        @(posedge clk); #1;
        driveReq(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
        waitReady(1'b0, ok);
        checkFlag("hold_port0_granted", ok, 1'b1);
        @(posedge clk); #1;
        driveReq(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D);
        driveReq(1'b1, 1'b1, 1'b0, 32'h20, 32'h5555_AAAA);
        @(negedge clk);
        checkFlag("hold_ready_access", req1_ready, 1'b0);
        @(negedge clk);
        checkFlag("hold_ready_done", req1_ready, 1'b0);
        @(negedge clk);
        checkFlag("hold_ready_idle", req1_ready, 1'b1);
        @(posedge clk); #1;
        driveReq(1'b1, 1'b0, 1'b0, 32'h20, 32'h5555_AAAA);
        @(negedge clk);
        checkFlag("hold_mem_rd", mem_rd, 1'b1);
        checkOutput("hold_mem_addr", mem_addr, 32'h20);
        checkOutput("hold_mem_wr_data", mem_wr_data, 32'h5555_AAAA);
        @(negedge clk);
        checkFlag("hold_rsp1_valid", rsp1_valid, 1'b1);
        checkOutput("hold_rsp1_rdata", rsp1_rdata, 32'hCAFE_F00D);

        $display("[TB] reset during ACCESS");
        @(posedge clk); #1;
        driveReq(1'b0, 1'b1, 1'b1, 32'h30, 32'h1111_1111);
        waitReady(1'b0, ok);
        checkFlag("rst_store_granted", ok, 1'b1);
        @(posedge clk); #2;
        checkFlag("rst_strobe_before", mem_wr, 1'b1);
        rst_n = 1'b0;
        driveReq(1'b0, 1'b0, 1'b1, 32'h30, 32'h1111_1111);
        #1;
        checkFlag("rst_strobe_async_drop", mem_wr, 1'b0);
        checkOutput("rst_addr_async_drop", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        driveReq(1'b0, 1'b1, 1'b0, 32'h30, 32'd0);
        driveReq(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkFlag("rst_first_gnt_port0", req0_ready, 1'b1);
        checkFlag("rst_first_gnt_not_port1", req1_ready, 1'b0);
        @(posedge clk); #1;
        driveReq(1'b0, 1'b0, 1'b0, 32'h30, 32'd0);
        waitReady(1'b1, ok);
        checkFlag("rst_second_gnt_port1", ok, 1'b1);
        @(posedge clk); #1;
        driveReq(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] random traffic");
        hs0 = hsCnt[0]; hs1 = hsCnt[1]; rs0 = rspCnt[0]; rs1 = rspCnt[1];
        issued = 0;
        cyc = 0;
        while ((issued < 1000 || req0_valid || req1_valid) && cyc < 20000) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            if (!req0_valid && issued < 1000 && $urandom_range(0, 3) != 0) begin
                randomReq(1'b0);
                issued++;
            end
            if (!req1_valid && issued < 1000 && $urandom_range(0, 3) != 0) begin
                randomReq(1'b1);
                issued++;
            end
        end
        repeat (4) @(negedge clk);
        checkFlag("rand_completed", cyc < 20000, 1'b1);
        checkOutput("rand_rsp_count_port0", rspCnt[0] - rs0, hsCnt[0] - hs0);
        checkOutput("rand_rsp_count_port1", rspCnt[1] - rs1, hsCnt[1] - hs1);
        checkOutput("rand_total_handshakes", (hsCnt[0] - hs0) + (hsCnt[1] - hs1), issued);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
